mii_tx_framer: RTL and testbench

MII_TX_FRAMER -- requirements
Module: mii_tx_framer

---
 rtl/mii_tx_framer.sv | 230 +++++++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload nibbles low-first, zero pad, CRC-32 FCS, then inter-frame gap.
// Latency: preamble one clock after s_tvalid; backpressure: one s_tready slot per byte, a missed slot aborts the frame.
module mii_tx_framer #(
    parameter int IFG_NIBBLES = 24,
    parameter int MIN_LEN     = 60,
    parameter int ADD_FCS     = 1
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       txen,
    output logic [3:0] txd,
    output logic       busy,
    output logic       tx_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAD   = 3'd4;
    localparam logic [2:0] S_FCS   = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;
    localparam logic [2:0] S_IFG   = 3'd7;

    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] PRE_LAST  = 16'd14;
    localparam logic [15:0] FCS_LAST  = 16'd7;
    // Counter reload so the IFG state occupies exactly IFG_NIBBLES cycles.
    localparam logic [15:0] IFG_LOAD  = (IFG_NIBBLES > 1) ? 16'(IFG_NIBBLES - 1) : 16'd0;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        nib_q, nib_d;
    logic [3:0]  hi_q, hi_d;
    logic        last_q, last_d;
    logic [15:0] count_q, count_d;
    logic [31:0] crc_q, crc_d;
    logic        txen_q, txen_d;
    logic [3:0]  txd_q, txd_d;
    logic        err_q, err_d;

    logic [15:0] count_inc;
    logic        do_accept, do_underrun, do_tail, do_ifg, do_pre;

    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    assign s_tready = (state_q == S_SFD) || (state_q == S_DRAIN) ||
                      ((state_q == S_DATA) && nib_q && !last_q);
    assign busy     = (state_q != S_IDLE);
    assign txen     = txen_q;
    assign txd      = txd_q;
    assign tx_err   = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        hi_d        = hi_q;
        last_d      = last_q;
        count_d     = count_q;
        crc_d       = crc_q;
        txen_d      = 1'b0;
        txd_d       = 4'h0;
        err_d       = 1'b0;
        do_accept   = 1'b0;
        do_underrun = 1'b0;
        do_tail     = 1'b0;
        do_ifg      = 1'b0;
        do_pre      = 1'b0;

        case (state_q)
            S_IDLE: begin
                do_pre = s_tvalid;
            end
            S_PRE: begin
                txen_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    txd_d   = 4'hD;
                    crc_d   = CRC_INIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    txd_d = 4'h5;
                end
            end
            S_SFD: begin
                do_accept   = s_tvalid;
                do_underrun = !s_tvalid;
            end
            S_DATA: begin
                if (!nib_q) begin
                    txen_d = 1'b1;
                    txd_d  = hi_q;
                    nib_d  = 1'b1;
                    crc_d  = crc_nib(crc_q, hi_q);
                end else if (!last_q) begin
                    do_accept   = s_tvalid;
                    do_underrun = !s_tvalid;
                end else begin
                    do_tail = 1'b1;
                end
            end
            S_PAD: begin
                if (!nib_q) begin
                    txen_d = 1'b1;
                    nib_d  = 1'b1;
                    crc_d  = crc_nib(crc_q, 4'h0);
                end else begin
                    do_tail = 1'b1;
                end
            end
            S_FCS: begin
                if (cnt_q == FCS_LAST) begin
                    do_ifg = 1'b1;
                end else begin
                    txen_d = 1'b1;
                    txd_d  = ~crc_q[3:0];
                    crc_d  = {4'hF, crc_q[31:4]};
                    cnt_d  = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                do_ifg = s_tvalid && s_tlast;
            end
            S_IFG: begin
                // The gap's last cycle doubles as the IDLE decision so back-to-back gaps are exact.
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                    do_pre  = s_tvalid;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Payload complete: pad up to MIN_LEN, then FCS or straight to the gap.
        if (do_tail) begin
            if (count_q < MIN_LEN_W) begin
                state_d = S_PAD;
                nib_d   = 1'b0;
                count_d = count_inc;
                txen_d  = 1'b1;
                txd_d   = 4'h0;
                crc_d   = crc_nib(crc_q, 4'h0);
            end else if (ADD_FCS != 0) begin
                state_d = S_FCS;
                cnt_d   = 16'd0;
                txen_d  = 1'b1;
                txd_d   = ~crc_q[3:0];
                crc_d   = {4'hF, crc_q[31:4]};
            end else begin
                do_ifg = 1'b1;
            end
        end

        if (do_accept) begin
            state_d = S_DATA;
            nib_d   = 1'b0;
            hi_d    = s_tdata[7:4];
            last_d  = s_tlast;
            count_d = count_inc;
            txen_d  = 1'b1;
            txd_d   = s_tdata[3:0];
            crc_d   = crc_nib(crc_q, s_tdata[3:0]);
        end

        if (do_underrun) begin
            state_d = S_DRAIN;
            err_d   = 1'b1;
        end

        if (do_ifg) begin
            state_d = S_IFG;
            cnt_d   = IFG_LOAD;
        end

        if (do_pre) begin
            state_d = S_PRE;
            cnt_d   = 16'd0;
            count_d = 16'd0;
            txen_d  = 1'b1;
            txd_d   = 4'h5;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            nib_q   <= 1'b0;
            hi_q    <= 4'h0;
            last_q  <= 1'b0;
            count_q <= 16'd0;
            crc_q   <= CRC_INIT;
            txen_q  <= 1'b0;
            txd_q   <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            hi_q    <= hi_d;
            last_q  <= last_d;
            count_q <= count_d;
            crc_q   <= crc_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: three parameterisations driven one at a time, expected nibbles
// queued when each frame is driven and popped as the selected DUT transmits.
module tb_mii_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata [3];
    logic [2:0] tvalid, tlast, tready, txen, busy, txerr;
    logic [3:0] txd [3];

    always #5 clk = ~clk;

    mii_tx_framer #(.IFG_NIBBLES(24), .MIN_LEN(60), .ADD_FCS(1)) u0 (
        .clkin(clk), .rst(rst), .s_tdata(tdata[0]), .s_tvalid(tvalid[0]), .s_tlast(tlast[0]),
        .s_tready(tready[0]), .txen(txen[0]), .txd(txd[0]), .busy(busy[0]), .tx_err(txerr[0]));
    mii_tx_framer #(.IFG_NIBBLES(24), .MIN_LEN(0), .ADD_FCS(1)) u1 (
        .clkin(clk), .rst(rst), .s_tdata(tdata[1]), .s_tvalid(tvalid[1]), .s_tlast(tlast[1]),
        .s_tready(tready[1]), .txen(txen[1]), .txd(txd[1]), .busy(busy[1]), .tx_err(txerr[1]));
    mii_tx_framer #(.IFG_NIBBLES(24), .MIN_LEN(0), .ADD_FCS(0)) u2 (
        .clkin(clk), .rst(rst), .s_tdata(tdata[2]), .s_tvalid(tvalid[2]), .s_tlast(tlast[2]),
        .s_tready(tready[2]), .txen(txen[2]), .txd(txd[2]), .busy(busy[2]), .tx_err(txerr[2]));

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         sel = 1;
    logic [3:0] exp_q [$];
    logic [7:0] frm [$];
    logic [3:0] fcs_123 [8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

    int   hi_run = 0, lo_run = 0, last_hi = 0, last_gap = 0, rise_cyc = 0, err_cnt = 0;
    logic prev_txen = 1'b0, fall_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_frame(input int min_len, input bit add_fcs);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF;
        n = 0;
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (frm[i]) begin
            exp_q.push_back(frm[i][3:0]);
            exp_q.push_back(frm[i][7:4]);
            c = ref_crc8(c, frm[i]);
            n++;
        end
        while (n < min_len) begin
            exp_q.push_back(4'h0);
            exp_q.push_back(4'h0);
            c = ref_crc8(c, 8'h00);
            n++;
        end
        if (add_fcs) begin
            c = ~c;
            for (int i = 0; i < 8; i++) exp_q.push_back(c[4*i +: 4]);
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input logic l);
        bit ok;
        ok = 1'b0;
        tdata[d]  = b;
        tlast[d]  = l;
        tvalid[d] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("handshake", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frm(input int d, input bit drop);
        foreach (frm[i]) send_byte(d, frm[i], (i == frm.size() - 1));
        if (drop) tvalid[d] = 1'b0;
    endtask

    task automatic wait_txen_low(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!txen[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("txen_fall", {31'd0, ok}, 32'd1);
    endtask

    task automatic count_busy(input int d, output int n, output bit saw);
        n   = 0;
        saw = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy[d]) break;
            n++;
            if (txen[d]) saw = 1'b1;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit saw;
        int e0;
        int c0;

        fork
            forever begin
                @(negedge clk);
                if (txen[sel]) begin
                    if (exp_q.size() == 0) chk("unexpected_txen", {31'd0, txen[sel]}, 32'd0);
                    else chk("txd", {28'd0, txd[sel]}, {28'd0, exp_q.pop_front()});
                    if (!prev_txen) begin
                        last_gap = lo_run;
                        rise_cyc = cyc;
                    end
                    hi_run++;
                    lo_run = 0;
                end else begin
                    if (prev_txen) begin
                        last_hi  = hi_run;
                        fall_err = txerr[sel];
                    end
                    hi_run = 0;
                    lo_run++;
                end
                if (txerr[sel]) err_cnt++;
                prev_txen = txen[sel];
            end
        join_none

        rst    = 1'b1;
        tvalid = 3'b000;
        tlast  = 3'b000;
        for (int i = 0; i < 3; i++) tdata[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txen", {29'd0, txen}, 32'd0);
        chk("rst_tready", {29'd0, tready}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_err", {29'd0, txerr}, 32'd0);
        chk("rst_txd", {20'd0, txd[0], txd[1], txd[2]}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "123456789" on MIN_LEN=0 / FCS instance, FCS hard-coded from the check value
        sel = 1;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(0, 1'b0);
        foreach (fcs_123[i]) exp_q.push_back(fcs_123[i]);
        send_frm(1, 1'b1);
        wait_txen_low(1);
        chk("crc_frame_len", last_hi, 42);
        chk("crc_frame_queue", exp_q.size(), 0);
        chk("crc_frame_err", {31'd0, fall_err}, 32'd0);
        count_busy(1, n, saw);
        chk("crc_frame_ifg", n, 24);
        chk("crc_frame_ifg_txen", {31'd0, saw}, 32'd0);

        // Back-to-back frames with s_tvalid held high
        frm = '{8'h11, 8'h22, 8'h33};
        push_frame(0, 1'b1);
        frm = '{8'h44, 8'h55};
        push_frame(0, 1'b1);
        frm = '{8'h11, 8'h22, 8'h33};
        send_frm(1, 1'b0);
        frm = '{8'h44, 8'h55};
        send_frm(1, 1'b1);
        wait_txen_low(1);
        chk("b2b_gap", last_gap, 24);
        chk("b2b_len", last_hi, 28);
        chk("b2b_queue", exp_q.size(), 0);
        count_busy(1, n, saw);
        chk("b2b_ifg", n, 24);

        // Underrun after byte 3 of 10
        e0  = err_cnt;
        frm = '{8'hA1, 8'hA2, 8'hA3};
        push_frame(0, 1'b0);
        for (int i = 1; i <= 3; i++) send_byte(1, 8'(8'hA0 + i), 1'b0);
        tvalid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("urun_txen", {31'd0, txen[1]}, 32'd0);
        chk("urun_drain_busy", {31'd0, busy[1]}, 32'd1);
        chk("urun_drain_tready", {31'd0, tready[1]}, 32'd1);
        for (int i = 4; i <= 10; i++) send_byte(1, 8'(8'hA0 + i), (i == 10));
        tvalid[1] = 1'b0;
        @(negedge clk);
        #1;
        count_busy(1, n, saw);
        chk("urun_ifg", n, 24);
        chk("urun_ifg_txen", {31'd0, saw}, 32'd0);
        chk("urun_err_pulses", err_cnt - e0, 1);
        chk("urun_err_at_fall", {31'd0, fall_err}, 32'd1);
        chk("urun_len", last_hi, 22);
        chk("urun_queue", exp_q.size(), 0);

        // Single byte padded to MIN_LEN=60
        sel = 0;
        frm = '{8'hAB};
        push_frame(60, 1'b1);
        send_frm(0, 1'b1);
        wait_txen_low(0);
        chk("pad_len", last_hi, 144);
        chk("pad_queue", exp_q.size(), 0);
        count_busy(0, n, saw);
        chk("pad_ifg", n, 24);

        // Reset during DATA, then an immediate fresh frame
        e0  = err_cnt;
        frm = '{8'h01, 8'h02};
        push_frame(0, 1'b0);
        exp_q.push_back(4'h3);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h03, 1'b0);
        rst       = 1'b1;
        tvalid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_txen", {31'd0, txen[0]}, 32'd0);
        chk("mrst_tready", {31'd0, tready[0]}, 32'd0);
        chk("mrst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mrst_err", {31'd0, txerr[0]}, 32'd0);
        chk("mrst_queue", exp_q.size(), 0);
        c0  = cyc;
        frm = '{8'h10, 8'h20, 8'h30, 8'h40};
        push_frame(60, 1'b1);
        send_frm(0, 1'b1);
        wait_txen_low(0);
        chk("mrst_no_ifg", rise_cyc, c0 + 1);
        chk("mrst_len", last_hi, 144);
        chk("mrst_queue2", exp_q.size(), 0);
        chk("mrst_no_err", err_cnt - e0, 0);
        count_busy(0, n, saw);
        chk("mrst_ifg", n, 24);

        // ADD_FCS=0, two bytes
        sel = 2;
        frm = '{8'h5A, 8'hC3};
        push_frame(0, 1'b0);
        send_frm(2, 1'b1);
        wait_txen_low(2);
        chk("nofcs_len", last_hi, 20);
        chk("nofcs_queue", exp_q.size(), 0);
        count_busy(2, n, saw);
        chk("nofcs_ifg", n, 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
